// File: rtl/text_writer.sv
`default_nettype none
// ============================================================================
//  Module   : text_writer
//  Purpose  : Minimal terminal front end for the 30x17 text VRAM. Accepts
//             bytes on a valid/ready handshake and interprets printable
//             glyphs, CR, LF, BS, FF and ESC-attribute. It maintains the
//             cursor and the current attribute and drives VRAM write port A.
//  Ports    : clk_i, rst_i (async, active-high)
//             chr_i[7:0], chr_valid_i        -> byte input
//             ready_o                        <- byte accepted this cycle
//             vram_cea_o, vram_ada_o[9:0],
//             vram_din_o[15:0]               <- VRAM port A write
//             cur_row_o[4:0], cur_col_o[4:0] <- cursor position
//  Revision : 1.0  initial release
// ============================================================================
module text_writer #(
    parameter logic [7:0] DEF_ATTR = 8'h07,
    parameter int         COLS     = 30,
    parameter int         ROWS     = 17
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  chr_i,
    input  logic        chr_valid_i,
    output logic        ready_o,
    output logic        vram_cea_o,
    output logic [9:0]  vram_ada_o,
    output logic [15:0] vram_din_o,
    output logic [4:0]  cur_row_o,
    output logic [4:0]  cur_col_o
);

    localparam logic [4:0] c_last_col = 5'(COLS - 1);
    localparam logic [4:0] c_last_row = 5'(ROWS - 1);
    localparam logic [7:0] c_blank    = 8'h20;

    typedef enum logic [1:0] {
        S_CLR_ALL = 2'd0,
        S_IDLE    = 2'd1,
        S_ESC     = 2'd2,
        S_CLR_ROW = 2'd3
    } state_t;

    state_t      r_state, w_state;
    // Shared clear pointer. Bit 10 flags the end of a full-screen clear,
    // bit 5 the end of a row clear; that terminal count costs the extra
    // cycle before ready_o rises again.
    logic [10:0] r_ptr,   w_ptr;
    logic [4:0]  r_row,   w_row;
    logic [4:0]  r_col,   w_col;
    logic [7:0]  r_attr,  w_attr;
    logic        r_ready, w_ready;
    logic        r_cea,   w_cea;
    logic [9:0]  r_ada,   w_ada;
    logic [15:0] r_din,   w_din;

    logic        w_accept;
    logic [4:0]  w_row_inc;

    assign w_accept  = chr_valid_i & r_ready;
    assign w_row_inc = (r_row == c_last_row) ? 5'd0 : r_row + 5'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_CLR_ALL;
            r_ptr   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_attr  <= DEF_ATTR;
            r_ready <= 1'b0;
            r_cea   <= 1'b0;
            r_ada   <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_row   <= w_row;
            r_col   <= w_col;
            r_attr  <= w_attr;
            r_ready <= w_ready;
            r_cea   <= w_cea;
            r_ada   <= w_ada;
            r_din   <= w_din;
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_row   = r_row;
        w_col   = r_col;
        w_attr  = r_attr;
        w_ready = r_ready;
        w_cea   = 1'b0;
        w_ada   = r_ada;
        w_din   = r_din;

        case (r_state)
            S_CLR_ALL: begin
                if (r_ptr[10]) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                end else begin
                    w_cea = 1'b1;
                    w_ada = r_ptr[9:0];
                    w_din = {r_attr, c_blank};
                    w_ptr = r_ptr + 11'd1;
                end
            end

            S_CLR_ROW: begin
                // All 32 words of the row, including the undisplayed ones.
                if (r_ptr[5]) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                end else begin
                    w_cea = 1'b1;
                    w_ada = {r_row, r_ptr[4:0]};
                    w_din = {r_attr, c_blank};
                    w_ptr = r_ptr + 11'd1;
                end
            end

            S_ESC: begin
                if (w_accept) begin
                    w_attr  = chr_i;
                    w_state = S_IDLE;
                end
            end

            default: begin // S_IDLE
                if (w_accept) begin
                    if (chr_i >= 8'h20) begin
                        w_cea = 1'b1;
                        w_ada = {r_row, r_col};
                        w_din = {r_attr, chr_i};
                        if (r_col == c_last_col) begin
                            w_col   = 5'd0;
                            w_row   = w_row_inc;
                            w_ptr   = '0;
                            w_ready = 1'b0;
                            w_state = S_CLR_ROW;
                        end else begin
                            w_col = r_col + 5'd1;
                        end
                    end else begin
                        case (chr_i)
                            8'h0D: w_col = 5'd0;
                            8'h0A: begin
                                w_col   = 5'd0;
                                w_row   = w_row_inc;
                                w_ptr   = '0;
                                w_ready = 1'b0;
                                w_state = S_CLR_ROW;
                            end
                            8'h08: begin
                                if (r_col != 5'd0) begin
                                    w_col = r_col - 5'd1;
                                end
                            end
                            8'h0C: begin
                                w_col   = 5'd0;
                                w_row   = 5'd0;
                                w_ptr   = '0;
                                w_ready = 1'b0;
                                w_state = S_CLR_ALL;
                            end
                            8'h1B: w_state = S_ESC;
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    assign ready_o    = r_ready;
    assign vram_cea_o = r_cea;
    assign vram_ada_o = r_ada;
    assign vram_din_o = r_din;
    assign cur_row_o  = r_row;
    assign cur_col_o  = r_col;

endmodule
`default_nettype wire
